// File: rtl/wb_arbiter2_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// No logic: grant state encoding, timeout read value, grant decode helper.
// Imported by the arbiter top and its testbench-facing modules.
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  // Read data returned to a master whose access was aborted by the watchdog.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

  // One-hot {m1,m0} grant seen by the outside world for a given state.
  function automatic logic [1:0] state_gnt(input arb_state_t s);
    return {s == ARB_GNT1, s == ARB_GNT0};
  endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// Bundle of both master ports, the switch-facing port and arbiter status.
// Pure wiring, no latency.
// Backpressure is Wishbone ACK; the slave modport is the arbiter's view.
interface wb_arbiter2_if;

  logic [31:0] m0_dat_i, m0_dat_o, m0_adr_i;
  logic [3:0]  m0_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o;

  logic [31:0] m1_dat_i, m1_dat_o, m1_adr_i;
  logic [3:0]  m1_sel_i;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o;

  logic [31:0] s_dat_o, s_adr_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;

  logic [1:0]  gnt_o;
  logic        to_flag_o, to_clr_i;

  // Arbiter side: takes master requests and switch responses, drives the rest.
  modport slave (
    input  m0_dat_i, m0_adr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
    output m0_dat_o, m0_ack_o,
    input  m1_dat_i, m1_adr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
    output m1_dat_o, m1_ack_o,
    output s_dat_o, s_adr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i,
    output gnt_o, to_flag_o,
    input  to_clr_i
  );

  // Environment side: masters, switch and status consumer.
  modport master (
    output m0_dat_i, m0_adr_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
    input  m0_dat_o, m0_ack_o,
    output m1_dat_i, m1_adr_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
    input  m1_dat_o, m1_ack_o,
    input  s_dat_o, s_adr_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i,
    input  gnt_o, to_flag_o,
    output to_clr_i
  );

endinterface

// File: rtl/wb_arbiter2_watchdog.sv
// Bus-timeout watchdog: counts strobe cycles without ACK, keeps a sticky flag.
// Fire is combinational in the cycle the count reaches TIMEOUT_CYC-1.
// A real ACK in the same cycle suppresses the fire; set beats clear on the flag.
module wb_arbiter2_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n_i,
  input  logic stb,
  input  logic ack,
  input  logic gnt_chg,
  input  logic clr,
  output logic fire,
  output logic flag
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  assign fire = stb & ~ack & (cnt == LAST);

  // Wait counter: runs only while an unanswered strobe is outstanding.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cnt <= '0;
    end else if (fire || !stb || ack || gnt_chg) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Sticky timeout flag; a fire in the same cycle as clear keeps it set.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      flag <= 1'b0;
    end else if (fire) begin
      flag <= 1'b1;
    end else if (clr) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter feeding one switch master port (WB_ARB_TIMEOUT_EN adds watchdog).
// Grant 1 cycle after CYC rise from idle; zero-bubble hand-over; datapath combinational.
// Grant locked for the whole CYC; losing master sees no ACK and simply waits.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter bit FIXED_PRIO  = 1'b0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  wb_arbiter2_if.slave  bus
);

  arb_state_t state, state_nxt;
  logic       last_gnt, last_gnt_nxt;   // 0: m0 owned the bus last, 1: m1
  logic [1:0] gnt;
  logic       c0, c1, s_stb, wd_fire, ack_any;

  assign c0 = bus.m0_cyc_i;
  assign c1 = bus.m1_cyc_i;

  // Grant state and round-robin history.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state    <= ARB_IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Arbitration: pick a winner from idle, hold while CYC stays high, hand over on release.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      ARB_IDLE: begin
        if (c0 && c1) begin
          state_nxt = (FIXED_PRIO || last_gnt) ? ARB_GNT0 : ARB_GNT1;
        end else if (c0) begin
          state_nxt = ARB_GNT0;
        end else if (c1) begin
          state_nxt = ARB_GNT1;
        end
      end
      ARB_GNT0: begin
        if (!c0) begin
          last_gnt_nxt = 1'b0;
          state_nxt    = c1 ? ARB_GNT1 : ARB_IDLE;
        end
      end
      ARB_GNT1: begin
        if (!c1) begin
          last_gnt_nxt = 1'b1;
          state_nxt    = c0 ? ARB_GNT0 : ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign gnt       = state_gnt(state);
  assign bus.gnt_o = gnt;

  // Switch-facing mux; m0 is the idle default so addresses never float.
  assign bus.s_adr_o = gnt[1] ? bus.m1_adr_i : bus.m0_adr_i;
  assign bus.s_sel_o = gnt[1] ? bus.m1_sel_i : bus.m0_sel_i;
  assign bus.s_dat_o = gnt[1] ? bus.m1_dat_i : bus.m0_dat_i;
  assign bus.s_we_o  = gnt[1] ? bus.m1_we_i  : bus.m0_we_i;
  assign bus.s_cyc_o = (gnt[0] & c0) | (gnt[1] & c1);
  assign s_stb       = (gnt[0] & c0 & bus.m0_stb_i) | (gnt[1] & c1 & bus.m1_stb_i);
  assign bus.s_stb_o = s_stb;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arbiter2_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .stb        (s_stb),
    .ack        (bus.s_ack_i),
    .gnt_chg    (state_nxt != state),
    .clr        (bus.to_clr_i),
    .fire       (wd_fire),
    .flag       (bus.to_flag_o)
  );
`else
  // Without the watchdog a hung slave hangs the bus; clear input has no effect.
  logic unused_cfg;
  assign unused_cfg    = &{1'b0, bus.to_clr_i, TIMEOUT_CYC[0]};
  assign wd_fire       = 1'b0;
  assign bus.to_flag_o = 1'b0;
`endif

  // Responses go only to the granted master; watchdog substitutes an error pattern.
  assign ack_any      = bus.s_ack_i | wd_fire;
  assign bus.m0_ack_o = gnt[0] & ack_any;
  assign bus.m1_ack_o = gnt[1] & ack_any;
  assign bus.m0_dat_o = wd_fire ? TIMEOUT_RDATA : bus.s_dat_i;
  assign bus.m1_dat_o = wd_fire ? TIMEOUT_RDATA : bus.s_dat_i;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Testbench: round-robin and fixed-priority arbiters driven by shared stimulus,
// checked every cycle against an ownership model, plus directed literal checks.
// Watchdog scenarios are included when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter2;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus
  logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic [31:0] s_dat = '0;
  logic        s_ack = 1'b0, to_clr = 1'b0;

  // Per-instance observed outputs (0: round-robin, 1: fixed priority)
  logic [1:0]  o_gnt   [2];
  logic [31:0] o_m0dat [2], o_m1dat [2], o_sdat [2], o_sadr [2];
  logic [3:0]  o_ssel  [2];
  logic        o_swe [2], o_scyc [2], o_sstb [2], o_m0ack [2], o_m1ack [2], o_flag [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    wb_arbiter2_if bus ();
    assign bus.m0_dat_i = m_dat[0];
    assign bus.m0_adr_i = m_adr[0];
    assign bus.m0_sel_i = m_sel[0];
    assign bus.m0_we_i  = m_we[0];
    assign bus.m0_cyc_i = m_cyc[0];
    assign bus.m0_stb_i = m_stb[0];
    assign bus.m1_dat_i = m_dat[1];
    assign bus.m1_adr_i = m_adr[1];
    assign bus.m1_sel_i = m_sel[1];
    assign bus.m1_we_i  = m_we[1];
    assign bus.m1_cyc_i = m_cyc[1];
    assign bus.m1_stb_i = m_stb[1];
    assign bus.s_dat_i  = s_dat;
    assign bus.s_ack_i  = s_ack;
    assign bus.to_clr_i = to_clr;
    assign o_gnt[gi]   = bus.gnt_o;
    assign o_m0dat[gi] = bus.m0_dat_o;
    assign o_m1dat[gi] = bus.m1_dat_o;
    assign o_sdat[gi]  = bus.s_dat_o;
    assign o_sadr[gi]  = bus.s_adr_o;
    assign o_ssel[gi]  = bus.s_sel_o;
    assign o_swe[gi]   = bus.s_we_o;
    assign o_scyc[gi]  = bus.s_cyc_o;
    assign o_sstb[gi]  = bus.s_stb_o;
    assign o_m0ack[gi] = bus.m0_ack_o;
    assign o_m1ack[gi] = bus.m1_ack_o;
    assign o_flag[gi]  = bus.to_flag_o;

    wb_arbiter2 #(
      .FIXED_PRIO  (gi == 1),
      .TIMEOUT_CYC (TO)
    ) u_dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .bus        (bus)
    );
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Model: who owns the bus (0 none, 1 m0, 2 m1), who owned it last, wait count, flag.
  int owner [2];
  int last  [2];
  int wcnt  [2];
  bit flag  [2];

  task automatic model_step(input int i);
    int o;
    bit busy;
    o    = owner[i];
    busy = 1'b0;
    if (o != 0) busy = m_cyc[o-1] && m_stb[o-1];
`ifdef WB_ARB_TIMEOUT_EN
    begin
      bit fire;
      fire = busy && !s_ack && (wcnt[i] == TO - 1);
      if (fire) flag[i] = 1'b1;
      else if (to_clr) flag[i] = 1'b0;
      wcnt[i] = (fire || !busy || s_ack) ? 0 : wcnt[i] + 1;
    end
`endif
    if (o == 0) begin
      if (m_cyc[0] && m_cyc[1]) owner[i] = (i == 1) ? 1 : ((last[i] == 1) ? 2 : 1);
      else if (m_cyc[0]) owner[i] = 1;
      else if (m_cyc[1]) owner[i] = 2;
    end else if (!m_cyc[o-1]) begin
      last[i]  = o;
      owner[i] = m_cyc[2-o] ? 3 - o : 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        owner[i] = 0; last[i] = 2; wcnt[i] = 0; flag[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Compare every DUT output against the model once per cycle.
  always @(negedge clk) begin : p_cmp
    int o, s;
    bit sc, ss, wd;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        o  = owner[i];
        s  = (o == 2) ? 1 : 0;
        sc = (o != 0) && m_cyc[s];
        ss = sc && m_stb[s];
        wd = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        wd = ss && !s_ack && (wcnt[i] == TO - 1);
`endif
        chk($sformatf("i%0d_gnt", i), o_gnt[i], (o == 1) ? 2'b01 : (o == 2) ? 2'b10 : 2'b00);
        chk($sformatf("i%0d_s_adr", i), o_sadr[i], m_adr[s]);
        chk($sformatf("i%0d_s_dat", i), o_sdat[i], m_dat[s]);
        chk($sformatf("i%0d_s_sel", i), o_ssel[i], m_sel[s]);
        chk($sformatf("i%0d_s_we", i), o_swe[i], m_we[s]);
        chk($sformatf("i%0d_s_cyc", i), o_scyc[i], sc);
        chk($sformatf("i%0d_s_stb", i), o_sstb[i], ss);
        chk($sformatf("i%0d_m0_ack", i), o_m0ack[i], (o == 1) && (s_ack || wd));
        chk($sformatf("i%0d_m1_ack", i), o_m1ack[i], (o == 2) && (s_ack || wd));
        chk($sformatf("i%0d_m0_dat", i), o_m0dat[i], wd ? 32'hFFFF_FFFF : s_dat);
        chk($sformatf("i%0d_m1_dat", i), o_m1dat[i], wd ? 32'hFFFF_FFFF : s_dat);
        chk($sformatf("i%0d_flag", i), o_flag[i], flag[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle(input int drop_pct, input int stb_pct, input int ack_pct);
    for (int k = 0; k < 2; k++) begin
      if (m_cyc[k]) begin
        if ($urandom_range(0, 99) < drop_pct) begin
          m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
        end else begin
          m_stb[k] = ($urandom_range(0, 99) < stb_pct);
        end
      end else if ($urandom_range(0, 99) < 35) begin
        m_cyc[k] = 1'b1;
        m_stb[k] = ($urandom_range(0, 99) < stb_pct);
      end
      m_adr[k] = $urandom;
      m_dat[k] = $urandom;
      m_sel[k] = 4'($urandom);
      m_we[k]  = 1'($urandom);
    end
    s_ack  = ($urandom_range(0, 99) < ack_pct);
    s_dat  = $urandom;
    to_clr = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_adr[k] = '0; m_dat[k] = '0; m_sel[k] = 4'hF;
    end
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_gnt", o_gnt[0], 2'b00);
    chk("rst_s_cyc", o_scyc[0], 1'b0);
    chk("rst_m0_ack", o_m0ack[0], 1'b0);
    chk("rst_flag", o_flag[0], 1'b0);

    // m0 single read at 0x1000
    tick(); m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_1000; m_we[0] = 1'b0;
    @(negedge clk); chk("rd_gnt_lat", o_gnt[0], 2'b00);
    tick(); @(negedge clk);
    chk("rd_gnt", o_gnt[0], 2'b01);
    chk("rd_s_adr", o_sadr[0], 32'h0000_1000);
    chk("rd_m0_ack_wait", o_m0ack[0], 1'b0);
    tick(); s_ack = 1'b1; s_dat = 32'hCAFE_BABE;
    @(negedge clk);
    chk("rd_m0_ack", o_m0ack[0], 1'b1);
    chk("rd_m0_dat", o_m0dat[0], 32'hCAFE_BABE);
    chk("rd_m1_ack", o_m1ack[0], 1'b0);
    tick(); m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0;

    // Tie after m0 owned last: round-robin picks m1, fixed priority picks m0
    tick(); m_cyc = 2'b11; m_stb = 2'b11;
    tick(); @(negedge clk);
    chk("tie_rr_gnt", o_gnt[0], 2'b10);
    chk("tie_fp_gnt", o_gnt[1], 2'b01);
    tick(); m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick(); @(negedge clk);
    chk("handover_gnt", o_gnt[0], 2'b01);
    tick(); m_cyc[0] = 1'b0; m_stb[0] = 1'b0;

    // m1 locked while toggling STB, m0 waiting
    tick(); m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick(); m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk($sformatf("lock_rr_%0d", b), o_gnt[0], 2'b10);
      chk($sformatf("lock_fp_%0d", b), o_gnt[1], 2'b10);
      tick(); m_stb[1] = b[0];
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick(); @(negedge clk);
    chk("unlock_gnt", o_gnt[0], 2'b01);
    tick(); m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick();

    // Async reset during an m1 strobe, then a tie goes to m0 and alternates
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick(); @(negedge clk);
    chk("pre_rst_gnt", o_gnt[0], 2'b10);
    tick(); rst_n = 1'b0; #1;
    chk("arst_gnt", o_gnt[0], 2'b00);
    chk("arst_s_cyc", o_scyc[0], 1'b0);
    chk("arst_s_stb", o_sstb[0], 1'b0);
    m_cyc = 2'b11; m_stb = 2'b11;
    tick(); rst_n = 1'b1;
    tick(); @(negedge clk);
    chk("post_rst_tie", o_gnt[0], 2'b01);
    tick(); m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick(); @(negedge clk);
    chk("alt_handover", o_gnt[0], 2'b10);
    tick(); m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick(); m_cyc = 2'b11; m_stb = 2'b11;
    tick(); @(negedge clk);
    chk("alt_tie", o_gnt[0], 2'b01);
    tick(); m_cyc = 2'b00; m_stb = 2'b00;
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Hung slave: watchdog acks on the 8th strobe cycle
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; s_ack = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick(); @(negedge clk);
      chk($sformatf("wd_ack_%0d", n), o_m0ack[0], (n == 8));
      if (n == 8) chk("wd_dat", o_m0dat[0], 32'hFFFF_FFFF);
    end
    tick(); m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk); chk("wd_flag_set", o_flag[0], 1'b1);
    tick(); to_clr = 1'b1;
    tick(); to_clr = 1'b0;
    @(negedge clk); chk("wd_flag_clr", o_flag[0], 1'b0);
`endif

    // Randomized traffic: responsive slave, then a mostly hung slave
    for (int c = 0; c < 3000; c++) begin
      tick(); rand_cycle(20, 60, 35);
    end
    for (int c = 0; c < 1500; c++) begin
      tick(); rand_cycle(3, 95, 0);
    end
    tick();
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
